// File: rtl/ladybird_uart_pkg.sv
// Shared definitions for the UART boot loader: state encoding, default frame
// start byte and header length.
package ladybird_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WRITE
    } loader_state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Address bytes followed by length bytes
    localparam int HDR_LEN = 8;

endpackage

// File: rtl/ladybird_uart_loader_timer.sv
// Inter-byte idle counter; expired fires on the cycle the count would reach
// TIMEOUT while enabled and not being cleared.
module ladybird_uart_loader_timer #(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign expired = enable && !clear && (count == TIMEOUT - 32'd1);

endmodule

// File: rtl/ladybird_uart_loader.sv
// Receives a MAGIC/address/length/payload frame from a UART byte stream and
// turns the payload into word-aligned, byte-enabled memory writes.
module ladybird_uart_loader
    import ladybird_uart_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000,
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] ADDR_LAST = 3'(HDR_LEN / 2 - 1);
    localparam logic [2:0] HDR_LAST  = 3'(HDR_LEN - 1);

    loader_state_t state, state_next;

    logic [2:0]  hdr_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic [31:0] remaining;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic        in_frame;
    logic        expired;
    logic        len_zero;
    logic        word_full;

    assign accept    = rx_valid && rx_ready;
    assign in_frame  = (state == ST_ADDR) || (state == ST_LEN) || (state == ST_DATA);
    assign len_zero  = ({rx_data, len_q[31:8]} == 32'd0);
    assign word_full = (byte_idx == 2'd3) || (remaining == 32'd1);

    ladybird_uart_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || !in_frame),
        .enable  (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && rx_data == MAGIC) state_next = ST_ADDR;
            ST_ADDR:  if (expired) state_next = ST_IDLE;
                      else if (accept && hdr_cnt == ADDR_LAST) state_next = ST_LEN;
            ST_LEN:   if (expired) state_next = ST_IDLE;
                      else if (accept && hdr_cnt == HDR_LAST)
                          state_next = len_zero ? ST_IDLE : ST_DATA;
            ST_DATA:  if (expired) state_next = ST_IDLE;
                      else if (accept && word_full) state_next = ST_WRITE;
            ST_WRITE: if (mem_ready)
                          state_next = (remaining != 32'd0) ? ST_DATA : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Header bytes arrive LSB first, so each one shifts in from the top
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt   <= '0;
            byte_idx  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            remaining <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= expired;
            case (state)
                ST_IDLE: begin
                    hdr_cnt  <= '0;
                    byte_idx <= '0;
                    wdata_q  <= '0;
                    strb_q   <= '0;
                end
                ST_ADDR: if (accept) begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                    addr_q  <= (hdr_cnt == ADDR_LAST) ? {rx_data, addr_q[31:10], 2'b00}
                                                      : {rx_data, addr_q[31:8]};
                end
                ST_LEN: if (accept) begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                    len_q   <= {rx_data, len_q[31:8]};
                    if (hdr_cnt == HDR_LAST) begin
                        remaining <= {rx_data, len_q[31:8]};
                        done_q    <= len_zero;
                    end
                end
                ST_DATA: begin
                    if (expired) begin
                        byte_idx  <= '0;
                        wdata_q   <= '0;
                        strb_q    <= '0;
                        remaining <= '0;
                    end else if (accept) begin
                        wdata_q[{byte_idx, 3'b000} +: 8] <= rx_data;
                        strb_q[byte_idx] <= 1'b1;
                        byte_idx <= byte_idx + 2'd1;
                        if (remaining != 32'd0) remaining <= remaining - 32'd1;
                    end
                end
                ST_WRITE: if (mem_ready) begin
                    addr_q   <= addr_q + 32'd4;
                    wdata_q  <= '0;
                    strb_q   <= '0;
                    byte_idx <= '0;
                    done_q   <= (remaining == 32'd0);
                end
                default: ;
            endcase
        end
    end

    // Everything is forced quiet during reset, independent of the registers
    always_comb begin
        rx_ready  = 1'b0;
        mem_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        if (!rst) begin
            rx_ready  = (state != ST_WRITE);
            mem_valid = (state == ST_WRITE);
            busy      = (state != ST_IDLE);
            done      = done_q;
            error     = error_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_strb  = strb_q;
        end
    end

endmodule

// File: tb/tb_ladybird_uart_loader.sv
// Self-checking bench for the UART loader: directed frames, randomized frames
// against a frame-level reference model, timeout, back-pressure and reset.
module tb_ladybird_uart_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int error_cnt = 0;
    int overlap_cnt = 0;
    int busy_bad_cnt = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    always #5 clk = ~clk;

    ladybird_uart_loader #(.TIMEOUT(32'd16), .MAGIC(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_strb  (mem_strb),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // mem_ready changes shortly after each rising edge so it is stable when sampled
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 2) != 0);
            default: mem_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) got_q.push_back({mem_addr, mem_wdata, mem_strb});
            if (done) done_cnt++;
            if (error) error_cnt++;
            if (done && error) overlap_cnt++;
            if ((done || error) && busy) busy_bad_cnt++;
        end
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_scoreboard();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        error_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 1000) begin
            errors++;
            $display("[TB] FAIL send_byte: rx_ready=%b after 1000 cycles, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] len,
                              input logic [7:0] pl[$], input int maxgap);
        send_byte(8'hA5, int'($urandom_range(0, maxgap)));
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], int'($urandom_range(0, maxgap)));
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], int'($urandom_range(0, maxgap)));
        for (int i = 0; i < pl.size(); i++) send_byte(pl[i], int'($urandom_range(0, maxgap)));
    endtask

    // Reference: payload split into aligned 4-byte groups, little-endian packed
    task automatic model_frame(input logic [31:0] addr, input logic [7:0] pl[$]);
        logic [31:0] a;
        wr_t w;
        a = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < pl.size(); i += 4) begin
            w.addr = a;
            w.data = '0;
            w.strb = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < pl.size()) begin
                    w.data[8*j +: 8] = pl[i+j];
                    w.strb[j] = 1'b1;
                end
            end
            exp_q.push_back(w);
            a = a + 32'd4;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 2000) begin
            errors++;
            $display("[TB] FAIL wait_idle: busy=%b after 2000 cycles, required 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, mem_valid, busy, done, error} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: {rx_ready,mem_valid,busy,done,error}=%b required 00000",
                     {rx_ready, mem_valid, busy, done, error});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h required 00000000", mem_addr);
        end
        checks++;
        if (mem_wdata !== 32'h0 || mem_strb !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_wdata_strb: got %h/%h required 00000000/0", mem_wdata, mem_strb);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: rx_ready=%b busy=%b required 1/0", rx_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [7:0] pl[$];
        clear_scoreboard();
        ready_mode = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(32'h0000_1000, 32'd8, pl, 2);
        wait_idle();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL directed8_count: got %0d writes required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'h0000_1000, 32'h4433_2211, 4'hF}) begin
                errors++;
                $display("[TB] FAIL directed8_w0: got %h required %h", got_q[0],
                         {32'h0000_1000, 32'h4433_2211, 4'hF});
            end
            checks++;
            if (got_q[1] !== {32'h0000_1004, 32'h8877_6655, 4'hF}) begin
                errors++;
                $display("[TB] FAIL directed8_w1: got %h required %h", got_q[1],
                         {32'h0000_1004, 32'h8877_6655, 4'hF});
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL directed8_done: got %0d pulses required 1", done_cnt);
        end

        clear_scoreboard();
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_frame(32'h0000_2003, 32'd5, pl, 1);
        wait_idle();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL directed5_count: got %0d writes required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'h0000_2000, 32'hDDCC_BBAA, 4'hF}) begin
                errors++;
                $display("[TB] FAIL directed5_w0: got %h required %h", got_q[0],
                         {32'h0000_2000, 32'hDDCC_BBAA, 4'hF});
            end
            checks++;
            if (got_q[1] !== {32'h0000_2004, 32'h0000_00EE, 4'h1}) begin
                errors++;
                $display("[TB] FAIL directed5_w1: got %h required %h", got_q[1],
                         {32'h0000_2004, 32'h0000_00EE, 4'h1});
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL directed5_done: got %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_ignore_len0();
        clear_scoreboard();
        ready_mode = 0;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL junk_ignored: busy=%b required 0", busy);
        end
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len0_done_timing: done=%b busy=%b required 1/0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len0_done_pulse: done=%b required 0", done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL len0_summary: writes=%0d done=%0d required 0/1", got_q.size(), done_cnt);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0]  pl[$];
        logic [31:0] addr;
        logic [7:0]  junk;
        int n;
        clear_scoreboard();
        ready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            addr = $urandom;
            n = int'($urandom_range(0, 13));
            if (f == 0) begin
                addr = 32'hFFFF_FFFE;
                n = 9;
            end
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            model_frame(addr, pl);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, int'($urandom_range(0, 2)));
            end
            send_frame(addr, 32'(n), pl, 3);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL random_write[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 8 || error_cnt != 0) begin
            errors++;
            $display("[TB] FAIL random_pulses: done=%0d error=%0d required 8/0", done_cnt, error_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_scoreboard();
        ready_mode = 0;
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        send_byte(8'h12, 1);
        send_byte(8'h34, 0);
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (error !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL timeout_early[%0d]: error=%b busy=%b required 0/1", j, error, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: error=%b busy=%b required 1/0", error, busy);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse_width: error=%b required 0", error);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || error_cnt != 1 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_summary: writes=%0d error=%0d done=%0d busy=%b required 0/1/0/0",
                     got_q.size(), error_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_stall();
        clear_scoreboard();
        ready_mode = 2;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 1); send_byte(8'h03, 0); send_byte(8'h04, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (mem_valid !== 1'b1 || rx_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_handshake[%0d]: mem_valid=%b rx_ready=%b required 1/0",
                         j, mem_valid, rx_ready);
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_strb} !== {32'h0000_3000, 32'h0403_0201, 4'hF}) begin
                errors++;
                $display("[TB] FAIL stall_stable[%0d]: got %h/%h/%h required 00003000/04030201/f",
                         j, mem_addr, mem_wdata, mem_strb);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ready_mode = 0;
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 2); send_byte(8'h08, 0);
        wait_idle();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d writes required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'h0000_3000, 32'h0403_0201, 4'hF} ||
                got_q[1] !== {32'h0000_3004, 32'h0807_0605, 4'hF}) begin
                errors++;
                $display("[TB] FAIL stall_writes: got %h %h required %h %h", got_q[0], got_q[1],
                         {32'h0000_3000, 32'h0403_0201, 4'hF}, {32'h0000_3004, 32'h0807_0605, 4'hF});
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL stall_done: got %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_reset_in_write();
        logic [7:0] pl[$];
        clear_scoreboard();
        ready_mode = 2;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(32'h0000_4000, 32'd4, pl, 0);
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstwrite_pending: mem_valid=%b required 1", mem_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwrite_abandon: mem_valid=%b busy=%b required 0/0", mem_valid, busy);
        end
        ready_mode = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || done_cnt != 0 || error_cnt != 0) begin
            errors++;
            $display("[TB] FAIL rstwrite_quiet: writes=%0d done=%0d error=%0d required 0/0/0",
                     got_q.size(), done_cnt, error_cnt);
        end
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(32'h0000_1000, 32'd8, pl, 1);
        wait_idle();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL rstwrite_reload_count: got %0d writes required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'h0000_1000, 32'h4433_2211, 4'hF} ||
                got_q[1] !== {32'h0000_1004, 32'h8877_6655, 4'hF}) begin
                errors++;
                $display("[TB] FAIL rstwrite_reload: got %h %h", got_q[0], got_q[1]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL rstwrite_done: got %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_pulse_invariants();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("[TB] FAIL done_error_overlap: got %0d cycles required 0", overlap_cnt);
        end
        checks++;
        if (busy_bad_cnt != 0) begin
            errors++;
            $display("[TB] FAIL busy_during_pulse: got %0d cycles required 0", busy_bad_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_len0();
        test_random_frames();
        test_timeout();
        test_stall();
        test_reset_in_write();
        test_pulse_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ladybird_uart_loader.md
LADYBIRD_UART_LOADER -- requirements
Module: ladybird_uart_loader

Interface
REQ-001 Parameter TIMEOUT, default 32'd1_000_000: idle cycles allowed between accepted bytes inside a frame.
REQ-002 Parameter MAGIC, default 8'hA5: frame start byte.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_valid  input  1  byte available from the UART receiver.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_ready  output  1  loader accepts rx_data this cycle.
REQ-008 mem_valid  output  1  memory write request.
REQ-009 mem_addr  output  32  word address of the write; bits [1:0] always 0.
REQ-010 mem_wdata  output  32  write data, little-endian byte packing.
REQ-011 mem_strb  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-012 mem_ready  input  1  memory accepts the request.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a frame completes.
REQ-015 error  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-016 Frame format: MAGIC, then 4 address bytes (LSB first), then 4 length bytes (LSB first, byte count), then length payload bytes.
REQ-017 A byte is accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-018 States: IDLE, ADDR, LEN, DATA, WRITE; rx_ready is 1 in IDLE/ADDR/LEN/DATA and 0 in WRITE.
REQ-019 IDLE: an accepted byte equal to MAGIC moves to ADDR; any other accepted byte is discarded with no output.
REQ-020 ADDR: the fourth accepted byte moves to LEN; the address register takes {addr[31:2],2'b00}, so low address bits are ignored.
REQ-021 LEN: on the fourth accepted byte, length 0 moves to IDLE with done pulsing the next cycle; any other length moves to DATA.
REQ-022 DATA: byte k of the current word goes to wdata[8k+7:8k] and sets strb[k]; k runs 0..3 and wraps.
REQ-023 DATA moves to WRITE on the cycle after the 4th byte of a word, or after the final payload byte when remaining length is 0 (partial word, upper strb bits 0).
REQ-024 WRITE: mem_valid is 1 and mem_addr/mem_wdata/mem_strb are held stable until mem_ready; mem_valid is 0 in every other state.
REQ-025 On the write handshake: addr += 4 (mod 2^32, wrap allowed) and wdata/strb clear; the state returns to DATA if bytes remain, else to IDLE with done pulsing the next cycle.
REQ-026 Remaining length is a 32-bit down-counter decremented per accepted payload byte; it never underflows.
REQ-027 Timeout: in ADDR/LEN/DATA, a counter resets on each accepted byte and increments otherwise; on reaching TIMEOUT it returns to IDLE, pulses error, and drops any partial word with no write issued.
REQ-028 There is no timeout in WRITE or IDLE; a stalled mem_ready stalls the loader indefinitely.
REQ-029 done and error are never high in the same cycle; busy is 0 in the cycle done or error is high.

Reset
REQ-030 While rst=1: state IDLE; rx_ready=0, mem_valid=0, busy=0, done=0, error=0; mem_addr/mem_wdata/mem_strb=0; all counters 0.
REQ-031 rst asserted mid-frame, including in WRITE with mem_valid high, abandons the frame with no done, no error, and no further write.
REQ-032 rx_ready becomes 1 the first cycle after rst deasserts.

Structure
REQ-033 A shared package ladybird_uart_pkg holds the loader state enum, the MAGIC default, and the frame header length constant (8).
REQ-034 The inter-byte timeout counter is a sub-module, ladybird_uart_loader_timer (inputs clear/enable, output expired).
REQ-035 No combinational path exists from mem_ready to rx_ready or from rx_valid to mem_valid.

Verification
REQ-036 Bytes A5, 00 10 00 00, 08 00 00 00, 11 22 33 44 55 66 77 88 -> writes (0x1000, 0x44332211, 4'hF) then (0x1004, 0x88776655, 4'hF); done pulses once.
REQ-037 Length 5, addr 0x2003, payload AA BB CC DD EE -> writes (0x2000, 0xDDCCBBAA, F) then (0x2004, 0x000000EE, 4'h1).
REQ-038 Bytes 00 FF A5 ... with length 0 -> first two bytes ignored, no write, done pulses one cycle after the last LEN byte.
REQ-039 TIMEOUT=16; stop after 2 payload bytes -> error pulses exactly 16 idle cycles after the last byte, no write, state IDLE.
REQ-040 mem_ready held 0 for 10 cycles in WRITE -> mem_* stable and rx_ready=0 throughout; continues after the handshake.
REQ-041 rst pulsed in WRITE -> mem_valid=0 next cycle; a following full frame loads correctly.
